// File: rtl/rtc_bus_scheduler.sv
// Sole owner of the RTC bus engine: arbitrates init > write (sw=1) > read (sw=0); optional RTC_SCHED_TIMEOUT_EN.
// Latency: pending flag in IDLE -> enable/busy/start next cycle; listo -> next start (or IDLE) next cycle.
// Backpressure: each transaction holds in WAIT until listo; with the macro, TIMEOUT cycles abort and retry.
module rtc_bus_scheduler #(
  parameter int READ_PERIOD = 1000,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw,
  input  logic       wr_req,
  input  logic       listo,
  output logic [1:0] posicion,
  output logic       start,
  output logic       enable_inicio,
  output logic       enable_escribir,
  output logic       enable_leer,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TICK_W = (READ_PERIOD > 2) ? $clog2(READ_PERIOD) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        pos_q, pos_d;
  logic              start_q, start_d;
  logic              en_init_q, en_init_d;
  logic              en_wr_q, en_wr_d;
  logic              en_rd_q, en_rd_d;
  logic              busy_q, busy_d;
  logic              init_pend_q, init_pend_d;
  logic              wr_pend_q, wr_pend_d;
  logic              read_pend_q, read_pend_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  logic              tick_wrap;
  logic              clr_init, clr_wr, clr_rd;
  logic              burst_done;
  logic              abort;
  logic              to_expire;
  logic [1:0]        last_pos;

  // Both periods below 2 cycles are not meaningful; nothing is built for them.
  if (READ_PERIOD < 2 || TIMEOUT < 2) begin : g_bad_params
  end

  assign tick_wrap = (tick_q == TICK_W'(READ_PERIOD - 1));
  assign tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
  // Init is a single transaction; write and read bursts cover registers 0..2.
  assign last_pos  = en_init_q ? 2'd0 : 2'd2;

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  assign to_expire = (state_q == S_WAIT) && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_ISSUE) begin
      to_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout_err_d = timeout_err_q | abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign to_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    start_d    = 1'b0;
    en_init_d  = en_init_q;
    en_wr_d    = en_wr_q;
    en_rd_d    = en_rd_q;
    busy_d     = busy_q;
    clr_init   = 1'b0;
    clr_wr     = 1'b0;
    clr_rd     = 1'b0;
    burst_done = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (init_pend_q) begin
          clr_init  = 1'b1;
          en_init_d = 1'b1;
        end else if (wr_pend_q && sw) begin
          clr_wr  = 1'b1;
          en_wr_d = 1'b1;
        end else if (read_pend_q && !sw) begin
          clr_rd  = 1'b1;
          en_rd_d = 1'b1;
        end
        if (clr_init || clr_wr || clr_rd) begin
          pos_d   = 2'd0;
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A listo coinciding with expiry is a completion, not a timeout.
        if (listo) begin
          if (pos_q == last_pos) begin
            burst_done = 1'b1;
          end else begin
            pos_d   = pos_q + 2'd1;
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end else if (to_expire) begin
          abort = 1'b1;
        end
        if (burst_done || abort) begin
          state_d   = S_IDLE;
          en_init_d = 1'b0;
          en_wr_d   = 1'b0;
          en_rd_d   = 1'b0;
          busy_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // New requests and abort re-arms win over the clear issued by a burst launch.
  assign init_pend_d = (init_pend_q & ~clr_init) | (abort & en_init_q);
  assign wr_pend_d   = (wr_pend_q & ~clr_wr) | (wr_req & sw) | (abort & en_wr_q);
  assign read_pend_d = (read_pend_q & ~clr_rd) | tick_wrap | (abort & en_rd_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pos_q       <= 2'd0;
      start_q     <= 1'b0;
      en_init_q   <= 1'b0;
      en_wr_q     <= 1'b0;
      en_rd_q     <= 1'b0;
      busy_q      <= 1'b0;
      init_pend_q <= 1'b1;
      wr_pend_q   <= 1'b0;
      read_pend_q <= 1'b0;
      tick_q      <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      start_q     <= start_d;
      en_init_q   <= en_init_d;
      en_wr_q     <= en_wr_d;
      en_rd_q     <= en_rd_d;
      busy_q      <= busy_d;
      init_pend_q <= init_pend_d;
      wr_pend_q   <= wr_pend_d;
      read_pend_q <= read_pend_d;
      tick_q      <= tick_d;
    end
  end

  assign posicion        = pos_q;
  assign start           = start_q;
  assign enable_inicio   = en_init_q;
  assign enable_escribir = en_wr_q;
  assign enable_leer     = en_rd_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler with READ_PERIOD=100, TIMEOUT=16.
module tb_rtc_bus_scheduler;

  localparam int RP = 100;
  localparam int TO = 16;

  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_INIT = 3'b100;
  localparam logic [2:0] T_WR   = 3'b010;
  localparam logic [2:0] T_RD   = 3'b001;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       sw     = 1'b0;
  logic       wr_req = 1'b0;
  logic       listo  = 1'b0;
  logic [1:0] posicion;
  logic       start;
  logic       enable_inicio;
  logic       enable_escribir;
  logic       enable_leer;
  logic       busy;
  logic       timeout_err;
  logic [2:0] en_vec;

  int errors = 0;
  int checks = 0;
  int cyc;
  int n_in = 0;
  int n_wr = 0;
  int n_rd = 0;
  int base_rd;
  int base_wr;

  assign en_vec = {enable_inicio, enable_escribir, enable_leer};

  rtc_bus_scheduler #(
    .READ_PERIOD(RP),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sw             (sw),
    .wr_req         (wr_req),
    .listo          (listo),
    .posicion       (posicion),
    .start          (start),
    .enable_inicio  (enable_inicio),
    .enable_escribir(enable_escribir),
    .enable_leer    (enable_leer),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (start) begin
      if (enable_inicio)   n_in = n_in + 1;
      if (enable_escribir) n_wr = n_wr + 1;
      if (enable_leer)     n_rd = n_rd + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (start !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_start"}, 32'(start), 32'd1);
  endtask

  // One transaction: expect start at register p, then answer listo three cycles later.
  task automatic do_txn(input string tag, input logic [1:0] p, input logic [2:0] typ);
    wait_start(tag);
    chk({tag, "_pos"},  32'(posicion), 32'(p));
    chk({tag, "_en"},   32'(en_vec),   32'(typ));
    chk({tag, "_busy"}, 32'(busy),     32'd1);
    step();
    chk({tag, "_start_1cyc"}, 32'(start), 32'd0);
    step();
    listo = 1'b1;
    step();
    listo = 1'b0;
  endtask

  task automatic do_burst(input string tag, input logic [2:0] typ, input int n);
    for (int i = 0; i < n; i++) begin
      do_txn($sformatf("%s_t%0d", tag, i), 2'(i), typ);
    end
    chk({tag, "_busy_end"}, 32'(busy),   32'd0);
    chk({tag, "_en_end"},   32'(en_vec), 32'(T_NONE));
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) step();
    chk("rst_pos",   32'(posicion),    32'd0);
    chk("rst_start", 32'(start),       32'd0);
    chk("rst_en",    32'(en_vec),      32'(T_NONE));
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_err",   32'(timeout_err), 32'd0);
    reset = 1'b1;

    // Init burst: one transaction at register 0.
    do_burst("init", T_INIT, 1);
    chk("init_nstart", 32'(n_in), 32'd1);

    // Run mode: wraps at cycles 100 and 200 give exactly two read bursts by cycle 250.
    base_rd = n_rd;
    do_burst("rd1", T_RD, 3);
    do_burst("rd2", T_RD, 3);
    while (cyc < 250) step();
    chk("rd_nstart_250", 32'(n_rd - base_rd), 32'd6);

    // Edit mode: the second request lands on the cycle the first burst clears wr_pend.
    sw      = 1'b1;
    base_wr = n_wr;
    wr_req  = 1'b1;
    step();
    step();
    wr_req  = 1'b0;
    do_burst("wr1", T_WR, 3);
    do_burst("wr2", T_WR, 3);
    chk("wr_nstart", 32'(n_wr - base_wr), 32'd6);

    // Wrap at cycle 300 leaves a read pending but suppressed in edit mode.
    base_rd = n_rd;
    while (cyc < 320) step();
    chk("rd_suppressed", 32'(n_rd - base_rd), 32'd0);
    chk("rd_supp_busy",  32'(busy),           32'd0);

    // Both pending with sw=1: write first, read follows once sw drops.
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    do_burst("wr_pri", T_WR, 3);
    sw = 1'b0;
    do_burst("rd_after", T_RD, 3);

    // Withheld listo.
    sw     = 1'b1;
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    wait_start("to");
`ifdef RTC_SCHED_TIMEOUT_EN
    repeat (16) step();
    chk("to_busy_16", 32'(busy),        32'd1);
    chk("to_err_16",  32'(timeout_err), 32'd0);
    step();
    chk("to_abort_busy", 32'(busy),        32'd0);
    chk("to_abort_err",  32'(timeout_err), 32'd1);
    chk("to_abort_en",   32'(en_vec),      32'(T_NONE));
    step();
    chk("to_retry_start", 32'(start),    32'd1);
    chk("to_retry_pos",   32'(posicion), 32'd0);
    chk("to_retry_en",    32'(en_vec),   32'(T_WR));
    do_burst("to_retry", T_WR, 3);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
`else
    repeat (40) step();
    chk("hold_busy",  32'(busy),        32'd1);
    chk("hold_start", 32'(start),       32'd0);
    chk("hold_err",   32'(timeout_err), 32'd0);
    chk("hold_en",    32'(en_vec),      32'(T_WR));
    chk("hold_pos",   32'(posicion),    32'd0);
    listo = 1'b1;
    step();
    listo = 1'b0;
    do_txn("hold_t1", 2'd1, T_WR);
    do_txn("hold_t2", 2'd2, T_WR);
    chk("hold_busy_end", 32'(busy),        32'd0);
    chk("hold_err_end",  32'(timeout_err), 32'd0);
`endif

    // Reset while a read waits at register 1.
    sw = 1'b0;
    do_txn("rst_t0", 2'd0, T_RD);
    wait_start("rst_t1");
    chk("rst_t1_pos", 32'(posicion), 32'd1);
    step();
    chk("rst_t1_wait_busy",  32'(busy),  32'd1);
    chk("rst_t1_wait_start", 32'(start), 32'd0);
    base_rd = n_rd;
    #2 reset = 1'b0;
    #1;
    chk("midrst_pos",   32'(posicion),    32'd0);
    chk("midrst_start", 32'(start),       32'd0);
    chk("midrst_en",    32'(en_vec),      32'(T_NONE));
    chk("midrst_busy",  32'(busy),        32'd0);
    chk("midrst_err",   32'(timeout_err), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    do_burst("reinit", T_INIT, 1);
    chk("reinit_no_read", 32'(n_rd - base_rd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Sequences all transactions to the shared RTC bus engine and arbitrates between three requesters: the one-time initialisation after reset, user writes in edit mode and periodic time reads. It drives the one-cycle `start` strobe, the transaction type enables and the register index `posicion`, then waits for the engine's `listo` completion pulse. It sits between the user-control logic and the bus engine. It replaces ad-hoc sequencing with a single owner of the bus.

## Interface
- `READ_PERIOD`, 1000: clock cycles between periodic read requests (≥2).
- `TIMEOUT`, 255: maximum WAIT cycles for `listo` before the scheduler aborts the burst (≥2).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sw` in 1: 1 = edit mode (writes allowed, periodic reads suppressed), 0 = run mode.
- `wr_req` in 1: one-cycle user write request. Ignored while `sw`=0.
- `listo` in 1: one-cycle completion pulse from the bus engine.
- `posicion` out 2: index of the register being accessed (0..2).
- `start` out 1: one-cycle pulse that launches one bus transaction.
- `enable_inicio`, `enable_escribir`, `enable_leer` out 1: type of the active burst. One-hot, or all 0 when idle.
- `busy` out 1: a burst is in progress.
- `timeout_err` out 1: sticky flag, set when any burst times out.

## Operation
- States: IDLE, ISSUE, WAIT.
- Pending flags:
  - `init_pend` is set by reset.
  - `wr_pend` is set by `wr_req` while `sw`=1.
  - `read_pend` is set when the tick counter wraps.
- Tick counter: free-running, counts 0..READ_PERIOD-1 and wraps. Repeated wraps while `read_pend` is already set collapse into one request.
- Selection in IDLE uses fixed priority: init > write (requires `sw`=1) > read (requires `sw`=0).
- Starting a burst:
  - The selected pending flag clears.
  - `posicion` is set to 0.
  - The type enable and `busy` are asserted.
  - The state goes to ISSUE.
- Burst length: init is 1 transaction (`posicion` 0). Write and read are 3 transactions (`posicion` 0,1,2).
- ISSUE: `start`=1 for exactly one cycle, then the state goes to WAIT.
- WAIT, on `listo`:
  - If `posicion` is the last index of the burst, go to IDLE and clear the enable and `busy`.
  - Otherwise increment `posicion` and go to ISSUE.
- `listo` outside WAIT is ignored.
- Timeout: a cycle counter clears on entry to WAIT. After TIMEOUT consecutive WAIT cycles without `listo`:
  - `timeout_err` is set.
  - The burst aborts to IDLE.
  - The burst's pending flag is set again, so the burst retries from `posicion` 0.
- `listo` in the same cycle as timeout expiry counts as completion.
- `wr_req` in the same cycle that a write burst clears `wr_pend`: the set wins, and a second write burst follows.
- A change of `sw` mid-burst does not abort the burst. It only affects the next selection.
- `timeout_err` clears only on reset.

## Timing
- Reset values:
  - State IDLE, `posicion`=0.
  - `start`, all enables, `busy` and `timeout_err` = 0.
  - `init_pend`=1, `wr_pend`=`read_pend`=0, tick counter 0.
- All outputs are registered.
- If a flag is pending in IDLE at cycle k:
  - Enables and `busy` go high at k+1.
  - `start`=1 at k+1.
  - WAIT begins at k+2.
- `listo` at cycle m in WAIT:
  - If more transactions remain, the next `start` is at m+1.
  - If it ends the burst, IDLE is at m+1 and a new burst can assert enables at m+2.
- Minimum burst duration for 3 transactions with immediate `listo`: 6 cycles.
- Reset asserted mid-burst takes effect immediately on all outputs, and the init burst is repeated after release.

## Configuration
- `RTC_SCHED_TIMEOUT_EN` defined: timeout counter and abort/retry logic are present, and `timeout_err` behaves as specified.
- Not defined: WAIT holds indefinitely until `listo`, there is no timeout counter, and `timeout_err` is tied 0.

## Test plan
All scenarios use READ_PERIOD=100 and TIMEOUT=16.
- Release reset, answer `listo` 3 cycles after each `start` → one init burst: `enable_inicio`=1, `posicion`=0, a single `start`, then `busy`=0.
- `sw`=0, leave running for 250 cycles → exactly 2 read bursts, each with `start` at `posicion` 0,1,2 and `enable_leer`=1 throughout.
- `sw`=1, pulse `wr_req` → write burst with `enable_escribir`=1 and 3 starts. Second `wr_req` on the burst-start cycle → a second write burst follows. Reads are suppressed while `sw`=1.
- `read_pend` and `wr_pend` both set with `sw`=1 → write burst first. After `sw`=0, the read burst runs.
- With the macro defined, withhold `listo` → abort after 16 WAIT cycles, `timeout_err`=1, the burst retries from `posicion` 0 and `timeout_err` stays 1. Without the macro → scheduler waits and `timeout_err`=0.
- Assert reset during WAIT of a read at `posicion`=1 → all outputs 0 immediately. After release, the init burst runs before any read.
